sseg_scan_scheduler: RTL

- Sequences the 4-digit seven-segment scan and shares the display between two number sources (client 0, client 1).
- Replaces the free-running anode counter/handler pair.
- Each slot has a dwell period and a pre-blank period to suppress ghosting.
- The selected value is latched per frame, so a frame never tears.
- Drives the number-to-digits / digit-select / hex-to-sseg / output chain.
- Its blank output forces all anodes off downstream.

---
 rtl/sseg_scan_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sseg_scan_scheduler.sv
// Four-digit seven-segment scan scheduler shared by two number sources.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module sseg_scan_scheduler #(
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int HOLD_SCANS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  req,
  input  logic [13:0] num0,
  input  logic [13:0] num1,
  output logic [1:0]  grant,
  output logic [13:0] value,
  output logic [1:0]  anode_index,
  output logic        blank,
  output logic        frame_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
  localparam int HW = $clog2(HOLD_SCANS + 1);
  localparam logic [1:0] FIRST =
    (BLANK_CYCLES == 0) ? SHOW : BLANK;

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] held, held_n, held_inc;
  logic          last, last_n;
  logic [1:0]    grant_n;
  logic [13:0]   value_n;
  logic [1:0]    idx_n;
  logic          blank_n, done_n;
  logic          own, oth, win, swap;

  function automatic logic [13:0] sat(input logic [13:0] n);
    return (n > 14'd9999) ? 14'd9999 : n;
  endfunction

  assign own = grant[1];
  assign oth = ~grant[1];
  assign held_inc = (held >= HW'(HOLD_SCANS)) ? held : held + HW'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    held_n  = held;
    last_n  = last;
    grant_n = grant;
    value_n = value;
    idx_n   = anode_index;
    done_n  = 1'b0;
    win     = 1'b0;
    swap    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          win     = (req == 2'b11) ? ~last : req[1];
          grant_n = win ? 2'b10 : 2'b01;
          last_n  = win;
          held_n  = '0;
          value_n = sat(win ? num1 : num0);
          idx_n   = 2'd0;
          cnt_n   = '0;
          state_n = FIRST;
        end
      end
      BLANK: begin
        if (cnt == CW'(BLANK_CYCLES - 1)) begin
          state_n = SHOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SHOW: begin
        if (cnt != CW'(DWELL_CYCLES - 1)) begin
          cnt_n = cnt + CW'(1);
        end else if (anode_index != 2'd3) begin
          cnt_n   = '0;
          idx_n   = anode_index + 2'd1;
          state_n = FIRST;
        end else begin
          cnt_n  = '0;
          idx_n  = 2'd0;
          done_n = 1'b1;
          if (!req[own] && !req[oth]) begin
            state_n = IDLE;
            grant_n = 2'b00;
            held_n  = held_inc;
          end else begin
            // a contender takes over once the owner has had its share
            swap    = req[oth] && (!req[own] || held_inc >= HW'(HOLD_SCANS));
            win     = swap ? oth : own;
            grant_n = win ? 2'b10 : 2'b01;
            held_n  = swap ? '0 : held_inc;
            last_n  = swap ? oth : last;
            value_n = sat(win ? num1 : num0);
            state_n = FIRST;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 2'b00;
        idx_n   = 2'd0;
        cnt_n   = '0;
      end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    blank_n = (state_n != SHOW) ||
              (idx_n == 2'd3 && value_n < 14'd1000) ||
              (idx_n == 2'd2 && value_n < 14'd100) ||
              (idx_n == 2'd1 && value_n < 14'd10);
`else
    blank_n = (state_n != SHOW);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      held        <= '0;
      last        <= 1'b1;
      grant       <= 2'b00;
      value       <= '0;
      anode_index <= 2'd0;
      blank       <= 1'b1;
      frame_done  <= 1'b0;
    end else if (en) begin
      state       <= state_n;
      cnt         <= cnt_n;
      held        <= held_n;
      last        <= last_n;
      grant       <= grant_n;
      value       <= value_n;
      anode_index <= idx_n;
      blank       <= blank_n;
      frame_done  <= done_n;
    end
  end

endmodule
